// File: rtl/uart_cmd_pkg.sv
// uart_cmd_pkg: register map, status bits, protocol bytes and state types for uart_cmd_master
package uart_cmd_pkg;
  localparam logic [1:0] REG_ODR = 2'd0;
  localparam logic [1:0] REG_IDR = 2'd1;
  localparam logic [1:0] REG_BSR = 2'd2;
  localparam logic [1:0] REG_SR  = 2'd3;
  localparam int SR_BUSY = 0;
  localparam int SR_RX   = 1;
  localparam int SR_FE   = 2;
  localparam logic [7:0] OP_WR   = 8'h57;
  localparam logic [7:0] OP_RD   = 8'h52;
  localparam logic [7:0] RSP_OK  = 8'h4B;
  localparam logic [7:0] RSP_BAD = 8'h3F;
  localparam logic [7:0] RSP_FE  = 8'h45;
  localparam logic [7:0] RSP_TMO = 8'h54;
  typedef enum logic [2:0] {S_INIT, S_IDLE, S_ADDR, S_DATA, S_MEM, S_REPLY} state_t;
  typedef enum logic [2:0] {L_IDLE, L_BSR, L_SR_RD, L_SR_WAIT, L_IDR_RD, L_IDR_WAIT, L_CLR, L_ODR} link_state_t;
endpackage

// File: rtl/uart_cmd_link.sv
// uart_cmd_link: byte get/put engine driving the simple_uart register port
module uart_cmd_link import uart_cmd_pkg::*; #(
  parameter int BAUD_DIV = 144
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        bsr_req_i,
  input  logic        get_req_i,
  input  logic        put_req_i,
  input  logic        abort_i,
  input  logic [7:0]  put_byte_i,
  output logic        done_o,
  output logic [7:0]  rx_byte_o,
  output logic        rx_fe_o,
  output logic        uart_sel_o,
  output logic [1:0]  uart_addr_o,
  output logic [31:0] uart_data_o,
  output logic        uart_we_o,
  input  logic [31:0] uart_data_i
);
  link_state_t state, next;
  logic is_put;
  logic unused_ok;
  assign unused_ok = ^uart_data_i[31:8];
  // state register plus latched operation kind, received byte and framing flag
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state     <= L_IDLE;
      is_put    <= 1'b0;
      rx_byte_o <= 8'h0;
      rx_fe_o   <= 1'b0;
    end else begin
      state <= next;
      if (state == L_IDLE) is_put <= put_req_i;
      if (state == L_SR_WAIT && !is_put && uart_data_i[SR_RX]) rx_fe_o <= uart_data_i[SR_FE];
      if (state == L_IDR_WAIT) rx_byte_o <= uart_data_i[7:0];
    end
  end
  // register access sequencing: SR poll, IDR read, SR clear, ODR write, BSR setup
  always_comb begin
    next        = state;
    uart_sel_o  = 1'b0;
    uart_we_o   = 1'b0;
    uart_addr_o = REG_ODR;
    uart_data_o = 32'h0;
    done_o      = 1'b0;
    case (state)
      L_IDLE:     next = bsr_req_i ? L_BSR : (put_req_i || get_req_i) ? L_SR_RD : L_IDLE;
      L_BSR:      begin uart_sel_o = 1'b1; uart_we_o = 1'b1; uart_addr_o = REG_BSR; uart_data_o = 32'(BAUD_DIV); done_o = 1'b1; next = L_IDLE; end
      L_SR_RD:    begin uart_sel_o = 1'b1; uart_addr_o = REG_SR; next = L_SR_WAIT; end
      L_SR_WAIT:  next = is_put ? (uart_data_i[SR_BUSY] ? L_SR_RD : L_ODR) : (uart_data_i[SR_RX] ? L_IDR_RD : L_SR_RD);
      L_IDR_RD:   begin uart_sel_o = 1'b1; uart_addr_o = REG_IDR; next = L_IDR_WAIT; end
      L_IDR_WAIT: next = L_CLR;
      L_CLR:      begin uart_sel_o = 1'b1; uart_we_o = 1'b1; uart_addr_o = REG_SR; done_o = 1'b1; next = L_IDLE; end
      L_ODR:      begin uart_sel_o = 1'b1; uart_we_o = 1'b1; uart_data_o = {24'h0, put_byte_i}; done_o = 1'b1; next = L_IDLE; end
      default:    next = L_IDLE;
    endcase
    if (abort_i) next = L_IDLE;
  end
endmodule

// File: rtl/uart_cmd_master.sv
// uart_cmd_master: UART command decoder issuing 32-bit memory bus accesses; UART_CMD_TIMEOUT_EN adds an inter-byte timeout
module uart_cmd_master import uart_cmd_pkg::*; #(
  parameter int BAUD_DIV       = 144,
  parameter int TIMEOUT_CYCLES = 5000000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        uart_sel_o,
  output logic [1:0]  uart_addr_o,
  output logic [31:0] uart_data_o,
  output logic        uart_we_o,
  input  logic [31:0] uart_data_i,
  output logic        mem_valid_o,
  input  logic        mem_ready_i,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic [3:0]  mem_wstrb_o,
  input  logic [31:0] mem_rdata_i
);
  state_t state, next;
  logic [1:0] cnt, rlen;
  logic [7:0] rx_byte;
  logic [31:0] addr, data;
  logic is_wr, bsr_req, get_req, put_req, done, rx_fe, tmo, bad_op, get_st, err;
  assign bad_op      = rx_fe || (rx_byte != OP_WR && rx_byte != OP_RD);
  assign get_st      = state == S_IDLE || state == S_ADDR || state == S_DATA;
  assign err         = done && get_st && (state == S_IDLE ? bad_op : rx_fe);
  assign mem_valid_o = state == S_MEM;
  assign mem_addr_o  = addr;
  assign mem_wdata_o = data;
  assign mem_wstrb_o = {4{mem_valid_o && is_wr}};
  uart_cmd_link #(.BAUD_DIV(BAUD_DIV)) u_link (
    .clk_i(clk_i), .rst_i(rst_i), .bsr_req_i(bsr_req), .get_req_i(get_req), .put_req_i(put_req),
    .abort_i(tmo), .put_byte_i(data[7:0]), .done_o(done), .rx_byte_o(rx_byte), .rx_fe_o(rx_fe),
    .uart_sel_o(uart_sel_o), .uart_addr_o(uart_addr_o), .uart_data_o(uart_data_o),
    .uart_we_o(uart_we_o), .uart_data_i(uart_data_i)
  );
`ifdef UART_CMD_TIMEOUT_EN
  logic [31:0] tmo_cnt;
  logic waiting;
  assign waiting = (state == S_ADDR || state == S_DATA) && !done;
  assign tmo     = waiting && tmo_cnt == 32'(TIMEOUT_CYCLES - 1);
  // inter-byte idle counter, cleared by every received byte and outside ADDR/DATA
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) tmo_cnt <= 32'h0;
    else tmo_cnt <= (waiting && !tmo) ? tmo_cnt + 32'h1 : 32'h0;
  end
`else
  localparam int unused_tmo = TIMEOUT_CYCLES;
  assign tmo = 1'b0;
`endif
  // frame state register
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state <= S_INIT;
    else state <= next;
  end
  // framing next-state and link requests
  always_comb begin
    next    = state;
    bsr_req = state == S_INIT;
    get_req = get_st;
    put_req = state == S_REPLY;
    case (state)
      S_INIT:  next = done ? S_IDLE : S_INIT;
      S_IDLE:  next = done ? (bad_op ? S_REPLY : S_ADDR) : S_IDLE;
      S_ADDR:  next = !done ? S_ADDR : rx_fe ? S_REPLY : cnt != 2'd3 ? S_ADDR : is_wr ? S_DATA : S_MEM;
      S_DATA:  next = !done ? S_DATA : rx_fe ? S_REPLY : cnt != 2'd3 ? S_DATA : S_MEM;
      S_MEM:   next = mem_ready_i ? S_REPLY : S_MEM;
      S_REPLY: next = (done && cnt == rlen) ? S_IDLE : S_REPLY;
      default: next = S_INIT;
    endcase
    if (tmo) next = S_REPLY;
  end
  // address/data assembly, reply staging and byte counting
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt   <= 2'd0;
      rlen  <= 2'd0;
      is_wr <= 1'b0;
      addr  <= 32'h0;
      data  <= 32'h0;
    end else if (tmo) begin
      data <= {24'h0, RSP_TMO};
      rlen <= 2'd0;
      cnt  <= 2'd0;
    end else if (state == S_MEM && mem_ready_i) begin
      data <= is_wr ? {24'h0, RSP_OK} : mem_rdata_i;
      rlen <= is_wr ? 2'd0 : 2'd3;
      cnt  <= 2'd0;
    end else if (err) begin
      data <= {24'h0, rx_fe ? RSP_FE : RSP_BAD};
      rlen <= 2'd0;
      cnt  <= 2'd0;
    end else if (done && state == S_IDLE) begin
      is_wr <= rx_byte == OP_WR;
      cnt   <= 2'd0;
    end else if (done && state == S_ADDR) begin
      addr <= {rx_byte, addr[31:8]};
      cnt  <= cnt + 2'd1;
    end else if (done && state == S_DATA) begin
      data <= {rx_byte, data[31:8]};
      cnt  <= cnt + 2'd1;
    end else if (done && state == S_REPLY) begin
      data <= data >> 8;
      cnt  <= cnt + 2'd1;
    end
  end
endmodule

// File: tb/tb_uart_cmd_master.sv
// tb_uart_cmd_master: scoreboard bench with a simple_uart slave model and a memory responder
module tb_uart_cmd_master;
`ifdef UART_CMD_TIMEOUT_EN
  localparam int TMO = 1000;
`else
  localparam int TMO = 5000000;
`endif
  typedef struct {logic [31:0] addr; logic [31:0] wdata; logic [3:0] wstrb; int len;} mem_exp_t;
  logic clk = 1'b0, rst_i = 1'b0;
  logic uart_sel_o, uart_we_o, mem_valid_o;
  logic [1:0] uart_addr_o;
  logic [31:0] uart_data_o, mem_addr_o, mem_wdata_o;
  logic [3:0] mem_wstrb_o;
  logic [31:0] uart_data_i = 32'h0, mem_rdata_i = 32'h0, rd_val = 32'h0;
  logic mem_ready_i = 1'b0;
  logic [7:0] exp_tx[$];
  mem_exp_t exp_mem[$];
  logic [8:0] rxq[$];
  int checks = 0, errors = 0, cyc = 0, busy_len = 6, mem_delay = 0, last_odr = 0, prev_odr = 0;
  int busy_cnt = 0, gap = 0, vcnt = 0, exp_len = 0;
  logic rx = 1'b0, fe = 1'b0, vprev = 1'b0, unstable = 1'b0;
  logic [7:0] rx_byte = 8'h0;
  logic [31:0] cap_a, cap_d;
  logic [3:0] cap_s;

  uart_cmd_master #(.BAUD_DIV(144), .TIMEOUT_CYCLES(TMO)) dut (
    .clk_i(clk), .rst_i(rst_i), .uart_sel_o(uart_sel_o), .uart_addr_o(uart_addr_o),
    .uart_data_o(uart_data_o), .uart_we_o(uart_we_o), .uart_data_i(uart_data_i),
    .mem_valid_o(mem_valid_o), .mem_ready_i(mem_ready_i), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_wstrb_o(mem_wstrb_o), .mem_rdata_i(mem_rdata_i)
  );

  always #5 clk = ~clk;

  // simple_uart slave model: registered read data, rx delivery from host queue, busy after ODR write
  always @(posedge clk) begin
    logic [8:0] ent;
    cyc <= cyc + 1;
    if (!rst_i) begin
      rx <= 1'b0; fe <= 1'b0; busy_cnt <= 0; gap <= 0; uart_data_i <= 32'h0;
    end else begin
      if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
      if (gap != 0) gap <= gap - 1;
      if (uart_sel_o && !uart_we_o)
        uart_data_i <= uart_addr_o == 2'd3 ? {29'h0, fe, rx, busy_cnt != 0} : uart_addr_o == 2'd1 ? {24'h0, rx_byte} : 32'h0;
      if (uart_sel_o && uart_we_o && uart_addr_o == 2'd3) begin
        rx <= 1'b0; fe <= 1'b0; gap <= 3;
      end else if (uart_sel_o && uart_we_o && uart_addr_o == 2'd0) begin
        busy_cnt <= busy_len;
      end else if (!rx && gap == 0 && rxq.size() != 0) begin
        ent = rxq.pop_front();
        rx_byte <= ent[7:0]; fe <= ent[8]; rx <= 1'b1;
      end
    end
  end

  // transmit monitor: every ODR write is popped against the expected reply stream
  always @(negedge clk) begin
    logic [7:0] e;
    if (rst_i && uart_sel_o && uart_we_o && uart_addr_o == 2'd0) begin
      checks++;
      prev_odr = last_odr;
      last_odr = cyc;
      if (exp_tx.size() == 0) begin
        errors++;
        $display("FAIL odr_unexpected got %h", uart_data_o);
      end else begin
        e = exp_tx.pop_front();
        if (uart_data_o !== {24'h0, e} || busy_cnt != 0) begin
          errors++;
          $display("FAIL odr_write got %h busy %0d want %h busy 0", uart_data_o, busy_cnt, e);
        end
      end
    end
  end

  // memory monitor and responder: checks request fields, stability and valid length
  always @(negedge clk) begin
    mem_exp_t e;
    if (mem_valid_o && !vprev) begin
      checks++;
      vcnt = 0; unstable = 1'b0;
      cap_a = mem_addr_o; cap_d = mem_wdata_o; cap_s = mem_wstrb_o;
      if (exp_mem.size() == 0) begin
        errors++; exp_len = 0;
        $display("FAIL mem_unexpected addr %h wstrb %h", mem_addr_o, mem_wstrb_o);
      end else begin
        e = exp_mem.pop_front();
        exp_len = e.len;
        if (mem_addr_o !== e.addr || mem_wstrb_o !== e.wstrb || (e.wstrb != 4'h0 && mem_wdata_o !== e.wdata)) begin
          errors++;
          $display("FAIL mem_req got a=%h d=%h s=%h want a=%h d=%h s=%h", mem_addr_o, mem_wdata_o, mem_wstrb_o, e.addr, e.wdata, e.wstrb);
        end
      end
    end else if (mem_valid_o) begin
      vcnt++;
      if (mem_addr_o !== cap_a || mem_wdata_o !== cap_d || mem_wstrb_o !== cap_s) unstable = 1'b1;
    end else if (vprev && rst_i) begin
      checks++;
      if (vcnt + 1 != exp_len || unstable) begin
        errors++;
        $display("FAIL mem_valid_len got %0d unstable %0d want %0d unstable 0", vcnt + 1, unstable, exp_len);
      end
    end
    mem_ready_i = mem_valid_o && vcnt == mem_delay;
    mem_rdata_i = mem_ready_i ? rd_val : 32'h0;
    vprev = mem_valid_o;
  end

  task automatic frame(input logic [71:0] b, input int n);
    for (int i = 0; i < n; i++) rxq.push_back({1'b0, b[8*i +: 8]});
  endtask

  task automatic expect_tx(input logic [31:0] b, input int n);
    for (int i = 0; i < n; i++) exp_tx.push_back(b[8*i +: 8]);
  endtask

  task automatic expect_mem(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, input int len);
    mem_exp_t e;
    e.addr = a; e.wdata = d; e.wstrb = s; e.len = len;
    exp_mem.push_back(e);
  endtask

  task automatic wait_idle(input int budget, input string nm);
    int n = 0;
    while ((exp_tx.size() != 0 || exp_mem.size() != 0 || rxq.size() != 0) && n < budget) begin
      @(posedge clk);
      n++;
    end
    checks++;
    if (n >= budget) begin
      errors++;
      $display("FAIL %s drain got tx %0d mem %0d rx %0d pending want 0", nm, exp_tx.size(), exp_mem.size(), rxq.size());
    end
    repeat (20) @(posedge clk);
  endtask

  task automatic check_reset(input string nm);
    int n = 0;
    @(negedge clk);
    rst_i = 1'b0;
    #1;
    checks++;
    if ({uart_sel_o, uart_we_o, uart_addr_o, uart_data_o, mem_valid_o, mem_addr_o, mem_wdata_o, mem_wstrb_o} !== '0) begin
      errors++;
      $display("FAIL %s reset_outputs got sel %b we %b valid %b addr %h want all 0", nm, uart_sel_o, uart_we_o, mem_valid_o, mem_addr_o);
    end
    rxq.delete(); exp_tx.delete(); exp_mem.delete();
    repeat (2) @(negedge clk);
    rst_i = 1'b1;
    @(negedge clk);
    checks++;
    if (!(uart_sel_o && uart_we_o && uart_addr_o == 2'd2 && uart_data_o == 32'd144)) begin
      errors++;
      $display("FAIL %s bsr_write got sel %b we %b addr %0d data %0d want 1 1 2 144", nm, uart_sel_o, uart_we_o, uart_addr_o, uart_data_o);
    end
    do begin @(negedge clk); n++; end while (!uart_sel_o && n < 5);
    checks++;
    if (!uart_sel_o || uart_we_o || uart_addr_o != 2'd3) begin
      errors++;
      $display("FAIL %s sr_poll got sel %b we %b addr %0d want 1 0 3", nm, uart_sel_o, uart_we_o, uart_addr_o);
    end
  endtask

  initial begin
    int t0;
    int n;
    check_reset("por");
    mem_delay = 3;
    expect_mem(32'h00000010, 32'hDEADBEEF, 4'hF, 4);
    expect_tx(32'h4B, 1);
    frame(72'hDEADBEEF0000001057, 9);
    wait_idle(3000, "write");
    mem_delay = 1; rd_val = 32'h12345678;
    expect_mem(32'h00000020, 32'h0, 4'h0, 2);
    expect_tx(32'h12345678, 4);
    frame(72'h0000002052, 5);
    wait_idle(3000, "read");
    expect_tx(32'h3F, 1);
    frame(72'h00, 1);
    wait_idle(1000, "bad_op");
    busy_len = 100;
    expect_tx(32'h3F, 1);
    frame(72'h00, 1);
    wait_idle(1000, "busy_a");
    expect_tx(32'h3F, 1);
    frame(72'h00, 1);
    wait_idle(1000, "busy_b");
    busy_len = 6;
    checks++;
    if (last_odr - prev_odr < 100) begin
      errors++;
      $display("FAIL busy_hold got gap %0d want >= 100", last_odr - prev_odr);
    end
    expect_tx(32'h45, 1);
    rxq.push_back(9'h057);
    rxq.push_back(9'h110);
    wait_idle(1000, "framing");
    mem_delay = 0; rd_val = 32'hA5C30F81;
    expect_mem(32'h00000044, 32'h0, 4'h0, 1);
    expect_tx(32'hA5C30F81, 4);
    frame(72'h0000004452, 5);
    wait_idle(3000, "read_after_fe");
    expect_mem(32'h12345678, 32'h04030201, 4'hF, 1);
    expect_tx(32'h4B, 1);
    frame(72'h040302011234567857, 9);
    wait_idle(3000, "write_fast");
`ifdef UART_CMD_TIMEOUT_EN
    expect_tx(32'h54, 1);
    t0 = cyc;
    rxq.push_back(9'h052);
    wait_idle(3000, "timeout");
    checks++;
    if (last_odr - t0 < 1000 || last_odr - t0 > 1060) begin
      errors++;
      $display("FAIL timeout_delay got %0d want 1000..1060", last_odr - t0);
    end
    expect_tx(32'h3F, 1);
    frame(72'h33, 1);
    wait_idle(1000, "after_timeout");
`else
    t0 = 0;
`endif
    mem_delay = 50;
    expect_mem(32'h00000100, 32'h55AA55AA, 4'hF, 51);
    frame(72'h55AA55AA0000010057, 9);
    n = 0;
    do begin @(negedge clk); n++; end while (!mem_valid_o && n < 1000);
    checks++;
    if (!mem_valid_o) begin
      errors++;
      $display("FAIL mid_bus_valid got %b want 1", mem_valid_o);
    end
    @(negedge clk);
    check_reset("mid_bus");
    expect_tx(32'h3F, 1);
    frame(72'h00, 1);
    wait_idle(1000, "after_reset");
    $display("CHECKS %0d ERRORS %0d", checks, errors + t0 * 0);
    $finish;
  end
endmodule

// File: doc/uart_cmd_master.md
# uart_cmd_master

Bus initiator that drives the register port of the `simple_uart` peripheral from the opposite side. It polls the UART status register and reads received bytes. It decodes a small host command protocol, then performs 32-bit reads and writes on a picorv32-native memory bus. Replies go back out through the UART transmit register. It sits between the UART slave and the system bus as a debug/boot loader path, alongside the CPU.

## Interface
- `BAUD_DIV`, default 144: value written to UART_BSR after reset; gives 115200 baud at 50 MHz (tick = clk/(BAUD_DIV+1), baud = tick/3).
- `TIMEOUT_CYCLES`, default 5000000: inter-byte timeout. Used only with `UART_CMD_TIMEOUT_EN`.
- `clk_i`, input, 1: single clock.
- `rst_i`, input, 1: reset; asynchronous, active-low.
- `uart_sel_o`, output, 1: UART register select, one-cycle pulse per access.
- `uart_addr_o`, output, 2: register address (0 ODR, 1 IDR, 2 BSR, 3 SR).
- `uart_data_o`, output, 32: write data to the UART.
- `uart_we_o`, output, 1: write enable, qualified by `uart_sel_o`.
- `uart_data_i`, input, 32: UART read data, registered by the slave.
- `mem_valid_o`, output, 1: memory request.
- `mem_ready_i`, input, 1: memory accept/complete.
- `mem_addr_o`, output, 32: byte address, passed unmodified.
- `mem_wdata_o`, output, 32: write data.
- `mem_wstrb_o`, output, 4: 4'hF for write, 4'h0 for read.
- `mem_rdata_i`, input, 32: read data, sampled when `mem_valid_o && mem_ready_i`.

## Operation
- **Protocol** (all multi-byte fields little-endian):
  - Write command: 0x57 'W', A0..A3, D0..D3 → memory write, reply 0x4B 'K'.
  - Read command: 0x52 'R', A0..A3 → memory read, reply D0..D3.
  - Any other opcode → reply 0x3F '?'.
- **Get byte:**
  - Read SR; repeat until bit1 (rx) = 1.
  - Read IDR.
  - Write SR (any data) to clear rx/fe.
  - If SR bit2 (fe) was 1: abort the frame, reply 0x45 'E', return to IDLE.
- **Put byte:**
  - Read SR; repeat until bit0 (busy) = 0.
  - Write ODR with {24'b0, byte}.
  - Never write ODR without a preceding busy=0 read. The slave drops ODR writes while busy.
- **States:**
  - INIT: write BSR ← BAUD_DIV, then go to IDLE.
  - IDLE: get opcode, then go to ADDR, or to REPLY with '?'.
  - ADDR: 4 bytes, byte counter 0..3.
  - DATA: 4 bytes, write command only.
  - MEM: assert the request and hold it until ready.
  - REPLY: put 1 or 4 bytes, then go to IDLE.
- Address and data assemble by shifting right: each new byte enters at [31:24]. After 4 bytes, byte0 is at [7:0].
- Read reply is sent from a latched copy of `mem_rdata_i`, LSB byte first.
- RX is not polled during MEM or REPLY. The slave has no FIFO, so the host must wait for each reply before sending more.

## Timing
- **Reset values:** all outputs 0; state INIT; counters 0. Reset asserted mid-frame or mid-bus-cycle aborts immediately; INIT reruns after release.
- First UART access is the BSR write, in the cycle after the first clock edge with `rst_i` high.
- **UART read:**
  - `uart_sel_o`=1, `uart_we_o`=0 in cycle N.
  - `uart_data_i` is sampled at the end of cycle N+1; `uart_sel_o`=0 in N+1.
  - Minimum 2 cycles per read.
- **UART write:** `uart_sel_o`=`uart_we_o`=1 for exactly one cycle.
- Minimum idle gap between UART accesses: 0 cycles after the sample cycle.
- **Memory bus:**
  - `mem_valid_o` rises the cycle after the last frame byte's SR clear.
  - addr/wdata/wstrb stay stable while valid.
  - Valid drops the cycle after `mem_ready_i`=1.
  - `mem_ready_i` in the same cycle valid rises completes in one cycle.
- SR rx and fe both set: the fe path applies; the byte is discarded.

## Configuration
- **`UART_CMD_TIMEOUT_EN` defined:**
  - A counter resets on every received byte and counts in ADDR/DATA while waiting for a byte.
  - At TIMEOUT_CYCLES: abort the frame, reply 0x54 'T', go to IDLE.
  - IDLE never times out.
- **`UART_CMD_TIMEOUT_EN` undefined:** waits indefinitely; no counter logic.

## Structure
- **Package `uart_cmd_pkg`:**
  - Register addresses: ODR=0, IDR=1, BSR=2, SR=3.
  - SR bit indices: busy 0, rx 1, fe 2.
  - Opcode/reply constants: 0x57, 0x52, 0x4B, 0x3F, 0x45, 0x54.
  - State enum.
- **Sub-module `uart_cmd_link`:** byte get/put engine that owns all `uart_*` ports.
  - Get: req/done handshake with byte and fe outputs.
  - Put: req/done handshake with a byte input.
  - The top-level FSM handles framing and the memory bus only.

## Test plan
- **Reset:** hold `rst_i`=0 → all outputs 0. After release, first access is `uart_we_o`=1, addr 2, data 144; then SR reads with addr 3.
- **Write frame:** 57 10 00 00 00 EF BE AD DE, with `mem_ready_i` delayed 3 cycles →
  - one request: addr 0x00000010, wdata 0xDEADBEEF, wstrb F, valid held 4 cycles;
  - then an ODR write of 0x4B.
- **Read frame:** 52 20 00 00 00, `mem_rdata_i`=0x12345678 → ODR writes 78, 56, 34, 12 in order, each preceded by an SR read with busy=0.
- **Opcode and busy:**
  - Opcode 0x00 → ODR write 0x3F, no mem request.
  - SR busy held 1 for 100 cycles → no ODR write until busy reads 0.
- **Framing error:** fe=1 on the second byte of a write frame → SR clear write, ODR 0x45, no mem request. A following valid read frame completes correctly.
- **Timeout (`UART_CMD_TIMEOUT_EN`, TIMEOUT_CYCLES=1000):** 52 then silence → ODR 0x54 after ~1000 cycles, then back in IDLE.
